xbus_arbiter: RTL
=================

// Module: xbus_arbiter
// PURPOSE
//  Central XBus arbiter/phase sequencer. Drives the arbitration-phase strobe (sig_start) and grants the shared
//  bus to one of NUM_MASTERS requesters by round robin. Tracks the address and data phases
//  (sig_read/sig_write/sig_size/sig_wait) so it re-arbitrates only when a transfer ends.
//  Sits beside the slave monitor BFM on the DUT side of the XBus.
// PARAMETERS
//  NUM_MASTERS  2   number of requesters, legal 1..8
//  MAX_WAIT     16  max consecutive sig_wait=1 cycles in data phase before abort; 0 disables timeout
// PORTS
//  sig_clock    in   1            bus clock, all logic on posedge
//  sig_reset    in   1            reset: synchronous, active-low
//  sig_request  in   NUM_MASTERS  per-master bus request, level
//  sig_read     in   1            address-phase read strobe from granted master
//  sig_write    in   1            address-phase write strobe from granted master
//  sig_size     in   2            address-phase size: 00=1, 01=2, 10=4, 11=8 beats
//  sig_wait     in   1            slave wait, data beat accepted on a cycle with sig_wait=0
//  sig_start    out  1            arbitration-phase strobe
//  sig_grant    out  NUM_MASTERS  one-hot grant, held through address and data phases
//  sig_error    out  1            1-cycle pulse: protocol error or wait timeout
//  arb_state    out  2            current FSM state (debug/coverage)
// BEHAVIOUR
//  - All outputs are Moore, decoded from registers. No combinational input->output paths.
//  - Reset: sig_reset=0 at a posedge forces state=IDLE, sig_grant=0, sig_start=0, sig_error=0, rr_ptr=0,
//    beat/wait counters=0. Applies mid-transfer too; no completion is signalled.
//  - FSM states: IDLE(0) ARB(1) ADDR(2) DATA(3). sig_start=1 only in ARB.
//  - IDLE: unconditionally -> ARB on the next edge, so the first cycle after reset release is IDLE.
//  - ARB: sample sig_request at the edge ending ARB.
//    - Any request -> ADDR. Register the one-hot grant of the first requester at or after rr_ptr
//      (cyclic). Set rr_ptr <= winner+1 (mod NUM_MASTERS).
//    - No request -> stay in ARB (sig_start stays 1).
//    - Request changes during ADDR/DATA are ignored.
//  - ADDR: one cycle. Sample sig_read/sig_write/sig_size.
//    - read^write -> DATA, beats_left <= 1<<sig_size (4-bit), wait_cnt <= 0.
//    - read=write=0 (NOP) -> ARB, grant cleared.
//    - read=write=1 -> sig_error pulse next cycle, -> ARB, grant cleared.
//  - DATA: each edge with sig_wait=0 decrements beats_left and clears wait_cnt.
//    - The edge accepting the last beat (beats_left==1) -> ARB, grant cleared.
//    - sig_wait=1 increments wait_cnt. If MAX_WAIT!=0 and wait_cnt reaches MAX_WAIT-1 while sig_wait=1,
//      raise a sig_error pulse and -> ARB, grant cleared, rr_ptr unchanged.
//  - Latency: request to grant visible = 1 cycle after the ARB cycle. Back-to-back transfers have exactly
//    one ARB cycle between the last data beat and the next ADDR.
//  - Fairness: a continuously requesting master waits at most NUM_MASTERS-1 transfers.
//    NUM_MASTERS=1 -> always master 0.
//  - sig_error and a state change on the same edge are allowed. sig_error never lasts longer than 1 cycle.
// STRUCTURE
//  - xbus_pkg:
//    - typedef enum logic[1:0] xbus_arb_state_e {IDLE,ARB,ADDR,DATA}
//    - function size_to_beats(logic[1:0])
//    - localparam XBUS_MAX_BEATS=8
//  - Sub-module xbus_rr_picker #(N): combinational; inputs req[N], ptr[$clog2(N)];
//    outputs onehot[N], idx, any. Instantiated once.
//  - Top: FSM, rr_ptr, beat and wait counters, output registers. About 180 lines.
// TESTING
//  1. Reset held 3 cycles with transfer in DATA -> grant=0, start=0, next cycle IDLE, then ARB (start=1).
//  2. req=2'b11 constant, each master does 1-beat write with wait=0
//     -> grants alternate 01,10,01,10; one ARB cycle between transfers.
//  3. Master 1 read, size=2'b11, sig_wait=1 on beats 3 and 6
//     -> grant held exactly 8 accepted beats + 2 wait cycles, then ARB.
//  4. ADDR with read=write=0 -> no DATA, back to ARB next cycle, sig_error=0.
//     With read=write=1 -> sig_error=1 for one cycle.
//  5. MAX_WAIT=4, sig_wait stuck 1 in DATA -> sig_error pulse after 4th wait cycle, -> ARB, grant=0.
//  6. req=0 for 10 cycles -> start=1 throughout, grant=0. req=2'b10 raised -> grant=2'b10 the cycle after next ARB.

Source files
------------

// File: rtl/xbus_pkg.sv
// Shared types and helpers for the XBus arbiter slice: FSM state encoding and
// address-phase size decoding.
package xbus_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        ARB  = 2'd1,
        ADDR = 2'd2,
        DATA = 2'd3
    } xbus_arb_state_e;

    localparam int XBUS_MAX_BEATS = 8;

    // sig_size encodes the burst length as a power of two: 1, 2, 4 or 8 beats.
    function automatic logic [3:0] size_to_beats(input logic [1:0] size);
        return 4'd1 << size;
    endfunction

endpackage

// File: rtl/xbus_rr_picker.sv
// Combinational round-robin picker: selects the first asserted request at or
// after the pointer, wrapping cyclically through all N requesters.
module xbus_rr_picker #(
    parameter int N  = 2,
    parameter int PW = (N > 1) ? $clog2(N) : 1
) (
    input  logic [N-1:0]  req_i,
    input  logic [PW-1:0] ptr_i,
    output logic [N-1:0]  onehot_o,
    output logic [PW-1:0] idx_o,
    output logic          any_o
);

    logic [PW-1:0] cand;

    always_comb begin
        onehot_o = '0;
        idx_o    = '0;
        any_o    = 1'b0;
        cand     = '0;
        for (int i = 0; i < N; i++) begin
            cand = PW'((int'(ptr_i) + i) % N);
            if (!any_o && req_i[cand]) begin
                any_o          = 1'b1;
                idx_o          = cand;
                onehot_o[cand] = 1'b1;
            end
        end
    end

endmodule

// File: rtl/xbus_arbiter.sv
// Central XBus arbiter and phase sequencer: round-robin grant in ARB, then
// tracks the address and data phases so the bus is re-arbitrated only when a transfer ends.
module xbus_arbiter
    import xbus_pkg::*;
#(
    parameter int NUM_MASTERS = 2,
    parameter int MAX_WAIT    = 16
) (
    input  logic                   sig_clock,
    input  logic                   sig_reset,
    input  logic [NUM_MASTERS-1:0] sig_request,
    input  logic                   sig_read,
    input  logic                   sig_write,
    input  logic [1:0]             sig_size,
    input  logic                   sig_wait,
    output logic                   sig_start,
    output logic [NUM_MASTERS-1:0] sig_grant,
    output logic                   sig_error,
    output logic [1:0]             arb_state
);

    localparam int PW = (NUM_MASTERS > 1) ? $clog2(NUM_MASTERS) : 1;
    localparam int WW = (MAX_WAIT > 0) ? $clog2(MAX_WAIT + 1) : 1;

    xbus_arb_state_e        state_q, state_d;
    logic [NUM_MASTERS-1:0] grant_q, grant_d;
    logic                   error_q, error_d;
    logic [PW-1:0]          rr_ptr_q, rr_ptr_d;
    logic [3:0]             beats_q, beats_d;
    logic [WW-1:0]          wait_q, wait_d;

    logic [NUM_MASTERS-1:0] pick_onehot;
    logic [PW-1:0]          pick_idx;
    logic                   pick_any;

    xbus_rr_picker #(
        .N  (NUM_MASTERS),
        .PW (PW)
    ) u_picker (
        .req_i    (sig_request),
        .ptr_i    (rr_ptr_q),
        .onehot_o (pick_onehot),
        .idx_o    (pick_idx),
        .any_o    (pick_any)
    );

    always_ff @(posedge sig_clock) begin
        if (!sig_reset) begin
            state_q  <= IDLE;
            grant_q  <= '0;
            error_q  <= 1'b0;
            rr_ptr_q <= '0;
            beats_q  <= '0;
            wait_q   <= '0;
        end else begin
            state_q  <= state_d;
            grant_q  <= grant_d;
            error_q  <= error_d;
            rr_ptr_q <= rr_ptr_d;
            beats_q  <= beats_d;
            wait_q   <= wait_d;
        end
    end

    always_comb begin
        state_d  = state_q;
        grant_d  = grant_q;
        error_d  = 1'b0;
        rr_ptr_d = rr_ptr_q;
        beats_d  = beats_q;
        wait_d   = wait_q;
        unique case (state_q)
            IDLE: state_d = ARB;
            ARB: begin
                if (pick_any) begin
                    state_d  = ADDR;
                    grant_d  = pick_onehot;
                    rr_ptr_d = (int'(pick_idx) == NUM_MASTERS - 1) ? '0 : pick_idx + PW'(1);
                end
            end
            ADDR: begin
                if (sig_read ^ sig_write) begin
                    state_d = DATA;
                    beats_d = size_to_beats(sig_size);
                    wait_d  = '0;
                end else begin
                    // NOP and read+write both abandon the transfer; only the latter is an error.
                    state_d = ARB;
                    grant_d = '0;
                    error_d = sig_read & sig_write;
                end
            end
            DATA: begin
                if (!sig_wait) begin
                    beats_d = beats_q - 4'd1;
                    wait_d  = '0;
                    if (beats_q == 4'd1) begin
                        state_d = ARB;
                        grant_d = '0;
                    end
                end else if (MAX_WAIT != 0 && wait_q == WW'(MAX_WAIT - 1)) begin
                    state_d = ARB;
                    grant_d = '0;
                    error_d = 1'b1;
                    wait_d  = '0;
                end else begin
                    wait_d = wait_q + WW'(1);
                end
            end
            default: state_d = IDLE;
        endcase
    end

    assign sig_start = (state_q == ARB);
    assign sig_grant = grant_q;
    assign sig_error = error_q;
    assign arb_state = state_q;

endmodule
